// File: rtl/cam_pipe_pkg.sv
// Shared CCD pipeline definitions: write-side state encoding and line geometry
// agreed between the line-buffer write controller and the read-enable generator.
package cam_pipe_pkg;

  localparam int COLS_DEF = 1280;
  localparam int ROWS_DEF = 1024;
  localparam int DW_DEF   = 10;
  localparam int AW_DEF   = 11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR_A = 2'd1,
    WR_B = 2'd2,
    DONE = 2'd3
  } wr_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) r++;
    return r;
  endfunction

endpackage

// File: rtl/line_buf_wr_ctrl_if.sv
// CCD pixel stream in, line-RAM write port out.
// master = camera/test side, slave = write controller.
interface line_buf_wr_ctrl_if
  import cam_pipe_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
);
  logic          iFVAL;
  logic          iDVAL;
  logic [DW-1:0] iDATA;
  logic          rama_wren;
  logic          ramb_wren;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          row_done;
  logic          frame_done;
  logic          line_err;

  modport master (
    output iFVAL, iDVAL, iDATA,
    input  rama_wren, ramb_wren, wr_addr, wr_data, row_done, frame_done, line_err
  );

  modport slave (
    input  iFVAL, iDVAL, iDATA,
    output rama_wren, ramb_wren, wr_addr, wr_data, row_done, frame_done, line_err
  );
endinterface

// File: rtl/edge_det_rise.sv
// Rising-edge detector against a registered copy of the input.
// RST_VAL=1 makes a level already high at reset release not count as an edge.
module edge_det_rise #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic aclr,
  input  logic din,
  output logic rise
);
  logic din_q;

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) din_q <= RST_VAL;
    else       din_q <= din;
  end

  assign rise = din & ~din_q;
endmodule

// File: rtl/line_buf_wr_ctrl.sv
// Ping-pongs complete CCD rows into line RAM A / line RAM B; ramb_wren also
// serves as the start trigger for the downstream read-enable generator.
//
// state | meaning
// IDLE  | waiting for a fresh iFVAL rising edge
// WR_A  | current row is written to line RAM A
// WR_B  | current row is written to line RAM B
// DONE  | frame complete, waiting for iFVAL low
module line_buf_wr_ctrl
  import cam_pipe_pkg::*;
#(
  parameter int COLS = COLS_DEF,
  parameter int ROWS = ROWS_DEF,
  parameter int DW   = DW_DEF,
  parameter int AW   = AW_DEF
) (
  input  logic                 clk,
  input  logic                 aclr,
  line_buf_wr_ctrl_if.slave    bus
);
  localparam int            RW       = (clog2(ROWS) < 1) ? 1 : clog2(ROWS);
  localparam logic [AW-1:0] LAST_PIX = AW'(COLS - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

  wr_state_e     state_q, state_d;
  logic [AW-1:0] pix_cnt_q, pix_cnt_d;
  logic [RW-1:0] row_cnt_q, row_cnt_d;
  logic          hold_q, hold_d;
  logic          line_err_q, line_err_d;
  logic          rama_wren_q, rama_wren_d;
  logic          ramb_wren_q, ramb_wren_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0] wr_data_q, wr_data_d;
  logic          row_done_q, row_done_d;
  logic          frame_done_q, frame_done_d;
  logic          fval_rise;
  logic          accept;

  // Armed high at reset so a frame already in progress cannot be picked up mid-way.
  edge_det_rise #(.RST_VAL(1'b1)) u_fval_rise (
    .clk  (clk),
    .aclr (aclr),
    .din  (bus.iFVAL),
    .rise (fval_rise)
  );

  assign accept = bus.iDVAL && !hold_q && (int'(pix_cnt_q) < COLS);

  always_comb begin
    state_d      = state_q;
    pix_cnt_d    = pix_cnt_q;
    row_cnt_d    = row_cnt_q;
    hold_d       = hold_q;
    line_err_d   = line_err_q;
    rama_wren_d  = 1'b0;
    ramb_wren_d  = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    row_done_d   = 1'b0;
    frame_done_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (fval_rise) begin
          line_err_d = 1'b0;
          row_cnt_d  = '0;
          pix_cnt_d  = '0;
          hold_d     = 1'b0;
          state_d    = WR_A;
        end
      end
      WR_A, WR_B: begin
        if (!bus.iFVAL) begin
          line_err_d = 1'b1;
          pix_cnt_d  = '0;
          hold_d     = 1'b0;
          state_d    = IDLE;
        end else if (bus.iDVAL) begin
          if (accept) begin
            rama_wren_d = (state_q == WR_A);
            ramb_wren_d = (state_q == WR_B);
            wr_addr_d   = pix_cnt_d;
            wr_data_d   = bus.iDATA;
            if (pix_cnt_q == LAST_PIX) begin
              row_done_d = 1'b1;
              pix_cnt_d  = '0;
              row_cnt_d  = row_cnt_q + RW'(1);
              // hold blocks the tail of a long row until iDVAL drops
              hold_d     = 1'b1;
              if (row_cnt_q == LAST_ROW) begin
                frame_done_d = 1'b1;
                state_d      = DONE;
              end else begin
                state_d = (state_q == WR_A) ? WR_B : WR_A;
              end
            end else begin
              pix_cnt_d = pix_cnt_q + AW'(1);
            end
          end else begin
            line_err_d = 1'b1;
          end
        end else begin
          hold_d = 1'b0;
          if (pix_cnt_q != '0) begin
            line_err_d = 1'b1;
            pix_cnt_d  = '0;
          end
        end
      end
      DONE: begin
        if (!bus.iFVAL) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      state_q      <= IDLE;
      pix_cnt_q    <= '0;
      row_cnt_q    <= '0;
      hold_q       <= 1'b0;
      line_err_q   <= 1'b0;
      rama_wren_q  <= 1'b0;
      ramb_wren_q  <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      row_done_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pix_cnt_q    <= pix_cnt_d;
      row_cnt_q    <= row_cnt_d;
      hold_q       <= hold_d;
      line_err_q   <= line_err_d;
      rama_wren_q  <= rama_wren_d;
      ramb_wren_q  <= ramb_wren_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      row_done_q   <= row_done_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.rama_wren  = rama_wren_q;
  assign bus.ramb_wren  = ramb_wren_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.row_done   = row_done_q;
  assign bus.frame_done = frame_done_q;
  assign bus.line_err   = line_err_q;
endmodule
